// File: rtl/gf_pkg.sv
// Shared types and field constants for the serial GF(2^M) arithmetic unit.
package gf_pkg;

  typedef enum logic {
    GF_MUL = 1'b0,
    GF_INV = 1'b1
  } gf_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  localparam logic [4:0] GF4_POLY = 5'b10011;
  localparam logic [8:0] GF8_POLY = 9'h11B;

endpackage

// File: rtl/gf_xtime.sv
// Multiply a field element by x, reducing modulo the field polynomial.
module gf_xtime #(
  parameter int unsigned M    = 4,
  parameter logic [M:0]  POLY = 5'b10011
) (
  input  logic [M-1:0] x,
  output logic [M-1:0] y
);

  always_comb begin
    y = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY[M-1:0] : '0);
  end

endmodule

// File: rtl/gf_mult_serial.sv
// Bit-serial MSB-first GF(2^M) multiplier; inversion runs as a^(2^M-2)
// via repeated square-and-multiply on the same serial datapath.
module gf_mult_serial
  import gf_pkg::*;
#(
  parameter int unsigned M    = 4,
  parameter logic [M:0]  POLY = GF4_POLY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [M-1:0] in_a,
  input  logic [M-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_z
);

  localparam int unsigned BC_W = $clog2(M);
  localparam int unsigned MC_W = $clog2(2 * M);
  localparam int unsigned NMUL = 2 * (M - 1);

  gf_state_e         state_q, state_d;
  gf_op_e            op_q, op_d;
  logic [M-1:0]      a_q, a_d;
  logic [M-1:0]      b_q, b_d;
  logic [M-1:0]      acc_q, acc_d;
  logic [M-1:0]      r_q, r_d;
  logic [M-1:0]      s_q, s_d;
  logic [M-1:0]      z_q, z_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [MC_W-1:0]   mul_cnt_q, mul_cnt_d;
  logic              sub_q, sub_d;

  logic [M-1:0]      mx, my, acc_x, step;

  // INV alternates s <- s*s (sub=0) and r <- r*s (sub=1)
  always_comb begin
    if (op_q == GF_MUL) begin
      mx = a_q;
      my = b_q;
    end else begin
      mx = sub_q ? r_q : s_q;
      my = s_q;
    end
  end

  gf_xtime #(
    .M    (M),
    .POLY (POLY)
  ) u_xtime (
    .x (acc_q),
    .y (acc_x)
  );

  always_comb begin
    step = acc_x ^ (my[bit_cnt_q] ? mx : '0);
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    r_d       = r_q;
    s_d       = s_q;
    z_d       = z_q;
    bit_cnt_d = bit_cnt_q;
    mul_cnt_d = mul_cnt_q;
    sub_d     = sub_q;
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d      = gf_op_e'(in_op);
          a_d       = in_a;
          b_d       = in_b;
          s_d       = in_a;
          r_d       = M'(1);
          acc_d     = '0;
          bit_cnt_d = BC_W'(M - 1);
          mul_cnt_d = '0;
          sub_d     = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (bit_cnt_q != '0) begin
          acc_d     = step;
          bit_cnt_d = bit_cnt_q - 1'b1;
        end else begin
          acc_d     = '0;
          bit_cnt_d = BC_W'(M - 1);
          if (op_q == GF_MUL) begin
            z_d     = step;
            state_d = DONE;
          end else begin
            if (sub_q) r_d = step;
            else       s_d = step;
            sub_d = ~sub_q;
            if (mul_cnt_q == MC_W'(NMUL - 1)) begin
              z_d     = step;
              state_d = DONE;
            end else begin
              mul_cnt_d = mul_cnt_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= GF_MUL;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      r_q       <= '0;
      s_q       <= '0;
      z_q       <= '0;
      bit_cnt_q <= '0;
      mul_cnt_q <= '0;
      sub_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      r_q       <= r_d;
      s_q       <= s_d;
      z_q       <= z_d;
      bit_cnt_q <= bit_cnt_d;
      mul_cnt_q <= mul_cnt_d;
      sub_q     <= sub_d;
    end
  end

  assign out_z = z_q;

endmodule

// File: tb/tb_gf_mult_serial.sv
// Directed + exhaustive bench for gf_mult_serial at M=4 (x^4+x+1) and M=8 (AES poly).
module tb_gf_mult_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       v4 = 1'b0, rdy4, op4 = 1'b0, ov4, ordy4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, z4;
  logic       v8 = 1'b0, rdy8, op8 = 1'b0, ov8, ordy8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, z8;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  gf_mult_serial #(.M(4), .POLY(5'b10011)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_op(op4),
    .in_a(a4), .in_b(b4), .out_valid(ov4), .out_ready(ordy4), .out_z(z4)
  );

  gf_mult_serial #(.M(8), .POLY(9'h11B)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_op(op8),
    .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(ordy8), .out_z(z8)
  );

  // Reference: carry-less product followed by long-division reduction.
  function automatic int gmul(int a, int b, int m, int poly);
    int p = 0;
    for (int i = 0; i < m; i++)
      if (((b >> i) & 1) == 1) p ^= (a << i);
    for (int i = 2 * m - 2; i >= m; i--)
      if (((p >> i) & 1) == 1) p ^= (poly << (i - m));
    return p;
  endfunction

  function automatic int ginv(int a, int m, int poly);
    if (a == 0) return 0;
    for (int c = 1; c < (1 << m); c++)
      if (gmul(a, c, m, poly) == 1) return c;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [31:0] rd_z(int sel);
    return sel ? 32'(z8) : 32'(z4);
  endfunction
  function automatic logic rd_ov(int sel);
    return sel ? ov8 : ov4;
  endfunction
  function automatic logic rd_rdy(int sel);
    return sel ? rdy8 : rdy4;
  endfunction

  task automatic set_in(int sel, logic v, logic op, int a, int b);
    if (sel != 0) begin v8 = v; op8 = op; a8 = 8'(a); b8 = 8'(b); end
    else          begin v4 = v; op4 = op; a4 = 4'(a); b4 = 4'(b); end
  endtask

  task automatic set_ordy(int sel, logic r);
    if (sel != 0) ordy8 = r; else ordy4 = r;
  endtask

  // One request: called #1 after a rising edge with the DUT idle.
  task automatic run(input int sel, input logic op, input int a, input int b,
                     input int stall, output int got);
    int m    = sel ? 8 : 4;
    int poly = sel ? 'h11B : 'h13;
    int lat  = op ? 2 * m * (m - 1) : m;
    int k    = 0;
    int expv;
    expv = op ? ginv(a, m, poly) : gmul(a, b, m, poly);
    exp_q.push_back(expv);
    check("in_ready_idle", 32'(rd_rdy(sel)), 32'd1);
    set_in(sel, 1'b1, op, a, b);
    @(posedge clk); #1;
    set_in(sel, 1'b0, ~op, $urandom, $urandom);
    while (!rd_ov(sel) && k < lat + 20) begin
      set_ordy(sel, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      k++;
      set_in(sel, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (!rd_ov(sel) && k < lat) check("in_ready_busy", 32'(rd_rdy(sel)), 32'd0);
    end
    set_ordy(sel, 1'b0);
    check("latency", 32'(k), 32'(lat));
    check("out_valid", 32'(rd_ov(sel)), 32'd1);
    got = int'(rd_z(sel));
    check("result", rd_z(sel), 32'(exp_q.pop_front()));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_z", rd_z(sel), 32'(got));
      check("stall_valid", 32'(rd_ov(sel)), 32'd1);
      check("stall_ready", 32'(rd_rdy(sel)), 32'd0);
    end
    set_ordy(sel, 1'b1);
    @(posedge clk); #1;
    set_ordy(sel, 1'b0);
    check("post_hs_valid", 32'(rd_ov(sel)), 32'd0);
    check("post_hs_ready", 32'(rd_rdy(sel)), 32'd1);
  endtask

  initial begin
    int got;
    int inv;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready4", 32'(rdy4), 32'd1);
    check("rst_valid4", 32'(ov4), 32'd0);
    check("rst_z4", 32'(z4), 32'd0);
    check("rst_ready8", 32'(rdy8), 32'd1);
    check("rst_valid8", 32'(ov8), 32'd0);
    check("rst_z8", 32'(z8), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 1'b0, 'h2, 'h8, 0, got);  check("mul4_2x8", 32'(got), 32'h3);
    run(0, 1'b0, 'hF, 'hF, 1, got);  check("mul4_FxF", 32'(got), 32'hA);
    run(0, 1'b1, 'h2, 'h0, 0, got);  check("inv4_2", 32'(got), 32'h9);
    run(0, 1'b1, 'h0, 'h5, 2, got);  check("inv4_0", 32'(got), 32'h0);
    run(1, 1'b0, 'h57, 'h83, 0, got); check("mul8_57x83", 32'(got), 32'hC1);
    run(1, 1'b1, 'h53, 'h00, 1, got); check("inv8_53", 32'(got), 32'hCA);
    run(0, 1'b0, 'h7, 'hB, 5, got);

    // Abort an INV two cycles in; result register must clear as well.
    set_in(0, 1'b1, 1'b1, 'h6, 'h0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0, 'h0, 'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 32'(rdy4), 32'd1);
    check("midrst_valid", 32'(ov4), 32'd0);
    check("midrst_z", 32'(z4), 32'd0);
    run(0, 1'b0, 'h3, 'h7, 0, got);  check("mul4_3x7", 32'(got), 32'h9);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run(0, 1'b0, a, b, $urandom_range(0, 3), got);

    for (int a = 0; a < 16; a++) begin
      run(0, 1'b1, a, $urandom_range(0, 15), $urandom_range(0, 3), inv);
      if (a != 0) begin
        run(0, 1'b0, a, inv, $urandom_range(0, 3), got);
        check("a_times_inv", 32'(got), 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gf_mult_serial.md
# gf_mult_serial

Parametrised, sequential GF(2^M) arithmetic unit. It multiplies two field elements, or inverts one element, over a programmable irreducible polynomial. The datapath is a bit-serial MSB-first multiplier, and inversion reuses it through iterated square-and-multiply. It replaces the fixed 4-bit combinational field multiplier wherever area matters more than latency, and it serves the wider (GF(2^8), AES-polynomial) datapaths through a valid/ready interface.

## Interface
- `M`, default 4: field degree (element width); legal range 2..16.
- `POLY`, default 5'b10011: irreducible polynomial, width M+1. `POLY[M]` must be 1. The default is x^4+x+1.
- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `in_valid` input, 1 bit: request valid.
- `in_ready` output, 1 bit: unit idle and able to accept a request.
- `in_op` input, 1 bit: 0 = MUL (z = a·b), 1 = INV (z = a^-1, with 0^-1 := 0).
- `in_a` input, M bits: operand a.
- `in_b` input, M bits: operand b; ignored for INV.
- `out_valid` output, 1 bit: result valid.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_z` output, M bits: result.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready`=1.
  - When `in_valid`=1, latch `in_op`, `in_a`, `in_b` and go to BUSY.
- **Serial multiply step:**
  - acc ← xtime(acc) ^ (b[i] ? a : 0), where xtime(x) = (x<<1)[M-1:0] ^ (x[M-1] ? POLY[M-1:0] : 0).
  - i runs from M-1 down to 0, one bit per cycle.
  - acc is cleared at the start of each multiply.
- **MUL:** one multiply of M cycles, then go to DONE.
- **INV:** computes a^(2^M-2).
  - Initialise r=1, s=a.
  - For k=1..M-1: s ← s·s, then r ← r·s.
  - That is 2(M-1) back-to-back serial multiplies, each of M cycles.
  - Result is r. a=0 yields 0 naturally, with no special case.
- **DONE:**
  - `out_valid`=1 and `out_z` is held stable.
  - When `out_ready`=1, go to IDLE.
- **Inputs while not in IDLE:** `in_*` changes are ignored. There is no overlap: a new request is accepted only in IDLE.
- **Counters:**
  - bit counter, $clog2(M) bits.
  - multiply counter, $clog2(2M) bits.
  - sub-step flag (square/multiply), 1 bit.
  - None of these wraps past its terminal value.
- **Arithmetic:** all arithmetic is XOR/AND in GF(2). No carries. All results are width M.

## Timing
- **Reset values:**
  - state=IDLE, `in_ready`=1, `out_valid`=0, `out_z`=0.
  - All internal registers are 0.
- **Reset mid-operation:** `rst` in BUSY or DONE aborts the request with no output, and the unit is in IDLE after that edge.
- **Acceptance:** the request is accepted on the edge E where `in_valid`&&`in_ready`. `in_ready` is 0 from E+1.
- **MUL latency:** `out_valid` is first high in the cycle after edge E+M.
- **INV latency:** `out_valid` is first high after edge E+2M(M-1). For M=4 this is 24 cycles; for M=8 it is 112.
- **Output handshake:**
  - The result transfers on the edge where `out_valid`&&`out_ready`.
  - `out_valid` is 0 and `in_ready` is 1 from the next cycle.
  - A new request is accepted no earlier than one cycle after the output handshake.
- **Backpressure:** `out_ready` low holds DONE indefinitely, with `out_z` unchanged.
- **`out_ready` high before DONE:** no effect.
- **Simultaneous `rst` and handshake:** `rst` wins.

## Structure
- **Package `gf_pkg`:**
  - `gf_op_e` enum (GF_MUL=0, GF_INV=1).
  - `gf_state_e` enum (IDLE, BUSY, DONE).
  - Constants GF4_POLY=5'b10011 and GF8_POLY=9'h11B.
- **Sub-module `gf_xtime`:** combinational, parametrised on M and POLY; multiply-by-x with reduction. It is instantiated once in the step datapath.
- **Top level:** FSM, counters, and the a/b/acc/r/s registers.

## Test plan
- **MUL, M=4, default POLY:**
  - a=0x2, b=0x8 → `out_z`=0x3 after 4 cycles.
  - a=0xF, b=0xF → `out_z`=0xA.
- **INV, M=4:**
  - a=0x2 → `out_z`=0x9 with `out_valid` after 24 cycles.
  - a=0x0 → `out_z`=0x0 at the same latency.
- **M=8, POLY=9'h11B:**
  - MUL 0x57·0x83 → 0xC1.
  - INV 0x53 → 0xCA after 112 cycles.
- **Backpressure and input stability:**
  - Hold `out_ready`=0 for 5 cycles in DONE → `out_z` stable and `in_ready`=0 throughout.
  - Then `out_ready`=1 → `in_ready`=1 on the next cycle.
  - Toggle `in_a`/`in_b` during BUSY → result unchanged.
- **Mid-operation reset:** assert `rst` 2 cycles into an INV → next cycle shows `in_ready`=1, `out_valid`=0, `out_z`=0. A following MUL 0x3·0x7 → 0x9.
- **Exhaustive, M=4:** all 256 MUL pairs and all 16 INV values checked against a golden reference model with random `out_ready` stalls. Every nonzero a must satisfy a·INV(a)=1.
